serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit
//   per clock, using a single full-subtractor cell and a borrow flip-flop.

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_if.sv | 33 +++
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the bit-serial subtractor.
// Port ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 8);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow flag enabled by SERIAL_SUB_OVF_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | one result bit per edge through the full-subtractor cell
// ST_DONE  | diff/bout valid (done=1); start here chains the next operation
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_full;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             d;
  logic             bo;
  logic             accept;
  logic             last;

  full_subtractor u_cell (
    .d  (d),
    .bo (bo),
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw)
  );

  assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last   = (state == ST_SHIFT) && (cnt == CNT_LAST);
  // r_sh keeps only the WIDTH-1 bits already produced; the current bit completes the word
  assign r_full = {d, r_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (bus.start) state <= ST_SHIFT;
        ST_SHIFT: if (last) state <= ST_DONE;
        ST_DONE:  state <= bus.start ? ST_SHIFT : ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      brw  <= bus.bin;
      cnt  <= '0;
    end else if (state == ST_SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_full[WIDTH-1:1];
      brw  <= bo;
      cnt  <= cnt + 1'b1;
      if (last) begin
        diff_q <= r_full;
        bout_q <= bo;
      end
    end
  end

  assign bus.busy = (state == ST_SHIFT);
  assign bus.done = (state == ST_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // Operand sign bits are shifted out during SHIFT, so keep them for the overflow test
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (last) begin
      ovf_q <= (a_msb != b_msb) && (d != a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] last_diff = 8'h00;
  int   lat;
  int   bcnt;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
    chk(tag, {31'd0, bus.ovf}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  // Issue one operation; optionally re-pulse start with junk operands at cycle glitch.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input logic [7:0] ed, input logic eb,
                        input logic eo, input int glitch);
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.bin = bi; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    lat  = 1;
    bcnt = 1;
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
      if (!bus.done) bcnt += int'(bus.busy);
      if (lat == glitch) begin
        bus.start = 1'b1; bus.a = ~av; bus.b = ~bv; bus.bin = ~bi;
      end else begin
        bus.start = 1'b0;
      end
      if (lat == 5) chk({tag, "_held"}, {24'd0, bus.diff}, {24'd0, last_diff});
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_busycyc"}, bcnt, 8);
    chk({tag, "_diff"}, {24'd0, bus.diff}, {24'd0, ed});
    chk({tag, "_bout"}, {31'd0, bus.bout}, {31'd0, eb});
    chk_ovf({tag, "_ovf"}, eo);
    last_diff = ed;
    @(negedge clk);
    chk({tag, "_donepulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_diff", {24'd0, bus.diff}, 32'd0);
    chk("rst_bout", {31'd0, bus.bout}, 32'd0);
    chk_ovf("rst_ovf", 1'b0);
    rst_n = 1'b1;

    run_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 0);
    run_op("t2", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
    run_op("t3a", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    run_op("t3b", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    run_op("t4", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 3);

    // Reset in the middle of an operation
    @(negedge clk);
    bus.a = 8'h5A; bus.b = 8'h3C; bus.bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_done", {31'd0, bus.done}, 32'd0);
    chk("t5_diff", {24'd0, bus.diff}, 32'd0);
    chk("t5_bout", {31'd0, bus.bout}, 32'd0);
    last_diff = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t5r", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 0);

    // start held high: back-to-back operations
    @(negedge clk);
    bus.a = 8'hC8; bus.b = 8'h64; bus.bin = 1'b0; bus.start = 1'b1;
    lat = 0;
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_lat1", lat, 9);
    chk("t6_diff1", {24'd0, bus.diff}, 32'h64);
    chk("t6_bout1", {31'd0, bus.bout}, 32'd0);
    chk_ovf("t6_ovf1", 1'b1);
    bus.a = 8'h01; bus.b = 8'h02; bus.bin = 1'b1;
    @(negedge clk);
    chk("t6_pulse1", {31'd0, bus.done}, 32'd0);
    chk("t6_busy2", {31'd0, bus.busy}, 32'd1);
    lat = 1;
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_period", lat, 9);
    chk("t6_diff2", {24'd0, bus.diff}, 32'hFE);
    chk("t6_bout2", {31'd0, bus.bout}, 32'd1);
    chk_ovf("t6_ovf2", 1'b0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("t6_pulse2", {31'd0, bus.done}, 32'd0);
    chk("t6_idle", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_hold", {24'd0, bus.diff}, 32'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
